// File: rtl/spi_flash_target_if.sv
// ----------------------------------------------------------------------------
// spi_flash_target_if
// Bundles the SPI pins and the backing-memory read port of the SPI flash
// responder.
//   slave  modport : the flash responder (spi_flash_target)
//   master modport : the environment (SPI initiator + backing memory)
// Signals:
//   spi_clk, spi_cs_n, spi_mosi : SPI initiator to target
//   spi_miso                    : SPI target to initiator
//   mem_word_addr, mem_rstrb    : word read request to backing memory
//   mem_rdata                   : word read data, valid one clk after strobe
//   busy, bad_cmd               : status
// ----------------------------------------------------------------------------
interface spi_flash_target_if #(
   parameter int ADDR_WIDTH = 15
);
   logic                  spi_clk;
   logic                  spi_cs_n;
   logic                  spi_mosi;
   logic                  spi_miso;
   logic [ADDR_WIDTH-1:0] mem_word_addr;
   logic                  mem_rstrb;
   logic [31:0]           mem_rdata;
   logic                  busy;
   logic                  bad_cmd;

   modport slave (
      input  spi_clk,
      input  spi_cs_n,
      input  spi_mosi,
      output spi_miso,
      output mem_word_addr,
      output mem_rstrb,
      input  mem_rdata,
      output busy,
      output bad_cmd
   );

   modport master (
      output spi_clk,
      output spi_cs_n,
      output spi_mosi,
      input  spi_miso,
      input  mem_word_addr,
      input  mem_rstrb,
      output mem_rdata,
      input  busy,
      input  bad_cmd
   );
endinterface

// File: rtl/spi_flash_target.sv
// ----------------------------------------------------------------------------
// spi_flash_target
// SPI NOR-flash responder (SPI mode 0) serving READ (0x03) and FAST READ
// (0x0B) out of a 32-bit word-wide backing memory. The SPI pins are
// oversampled on clk; spi_clk must stay high and low for at least
// SYNC_STAGES+2 clk each.
// Ports:
//   clk    : system clock (only clock)
//   reset  : synchronous, active-high reset
//   bus    : spi_flash_target_if.slave
//            spi_clk / spi_cs_n / spi_mosi in, spi_miso out,
//            mem_word_addr / mem_rstrb out, mem_rdata in,
//            busy (selected) and bad_cmd (unsupported opcode pulse) out
// ----------------------------------------------------------------------------
module spi_flash_target #(
   parameter int ADDR_WIDTH  = 15,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   spi_flash_target_if.slave  bus
);

   // Byte address width: word address plus two lane bits.
   localparam int BYTE_AW = ADDR_WIDTH + 2;

   localparam logic [BYTE_AW-1:0] ADDR_ONE = {{(BYTE_AW-1){1'b0}}, 1'b1};

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_ADDR    = 3'd2;
   localparam logic [2:0] ST_DUMMY   = 3'd3;
   localparam logic [2:0] ST_DATA    = 3'd4;
   localparam logic [2:0] ST_IGNORE  = 3'd5;
   localparam logic [2:0] ST_WAIT_CS = 3'd6;

   // Synchronizer chains, oldest sample in the top bit.
   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic                   sclk_prev_r;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   rise_s;
   logic                   fall_s;

   logic [2:0]             state_r;
   logic [4:0]             bit_cnt_r;
   logic [6:0]             cmd_r;
   logic                   dummy_r;
   logic [BYTE_AW-1:0]     addr_r;
   logic [2:0]             data_bit_r;
   logic [7:0]             miso_sh_r;
   logic                   miso_r;
   logic [31:0]            word_buf_r;
   logic                   rstrb_d_r;
   logic                   mem_rstrb_r;
   logic [ADDR_WIDTH-1:0]  mem_word_addr_r;
   logic                   busy_r;
   logic                   bad_cmd_r;

   logic [7:0]             cmd_next_s;
   logic [BYTE_AW-1:0]     addr_next_s;
   logic [BYTE_AW-1:0]     addr_inc_s;
   logic [7:0]             lane_byte_s;

   // Pin synchronizers. Deliberately not reset: the reset branch of the FSM
   // must see the live chip-select level to decide between IDLE and WAIT_CS.
   always_ff @(posedge clk) begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.spi_clk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0],   bus.spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
   end

   assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
   assign cs_s   = cs_sync_r[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
   assign rise_s = sclk_s & ~sclk_prev_r;
   assign fall_s = ~sclk_s & sclk_prev_r;

   // Shift-register next values and the incremented byte address (wraps
   // naturally at the width of addr_r).
   assign cmd_next_s  = {cmd_r, mosi_s};
   assign addr_next_s = {addr_r[BYTE_AW-2:0], mosi_s};
   assign addr_inc_s  = addr_r + ADDR_ONE;

   // Select the byte lane addressed by the two low byte-address bits.
   always_comb begin
      lane_byte_s = 8'h00;
      case (addr_r[1:0])
         2'd0:    lane_byte_s = word_buf_r[7:0];
         2'd1:    lane_byte_s = word_buf_r[15:8];
         2'd2:    lane_byte_s = word_buf_r[23:16];
         2'd3:    lane_byte_s = word_buf_r[31:24];
         default: lane_byte_s = 8'h00;
      endcase
   end

   // Transaction FSM, address/command shifting, fetch issue and MISO shifter.
   always_ff @(posedge clk) begin
      if (reset) begin
         // With chip select still low, park in WAIT_CS so the tail of the
         // aborted transfer is not decoded as a fresh command.
         state_r         <= cs_s ? ST_IDLE : ST_WAIT_CS;
         bit_cnt_r       <= 5'd0;
         cmd_r           <= 7'd0;
         dummy_r         <= 1'b0;
         addr_r          <= {BYTE_AW{1'b0}};
         data_bit_r      <= 3'd0;
         miso_sh_r       <= 8'h00;
         miso_r          <= 1'b0;
         word_buf_r      <= 32'h0000_0000;
         rstrb_d_r       <= 1'b0;
         mem_rstrb_r     <= 1'b0;
         mem_word_addr_r <= {ADDR_WIDTH{1'b0}};
         busy_r          <= 1'b0;
         bad_cmd_r       <= 1'b0;
      end else begin
         mem_rstrb_r <= 1'b0;
         bad_cmd_r   <= 1'b0;
         busy_r      <= ~cs_s;

         // Read data arrives one clk after the strobe; capture it the clk
         // after that. An in-flight fetch of an aborted transfer lands here
         // harmlessly because the next transfer refetches before reading.
         rstrb_d_r <= mem_rstrb_r;
         if (rstrb_d_r) begin
            word_buf_r <= bus.mem_rdata;
         end else begin
            word_buf_r <= word_buf_r;
         end

         if (cs_s) begin
            // Deselect has priority over any coincident spi_clk edge.
            state_r    <= ST_IDLE;
            miso_r     <= 1'b0;
            bit_cnt_r  <= 5'd0;
            data_bit_r <= 3'd0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  bit_cnt_r <= 5'd0;
                  state_r   <= ST_CMD;
               end

               ST_CMD: begin
                  if (rise_s) begin
                     cmd_r <= cmd_next_s[6:0];
                     if (bit_cnt_r == 5'd7) begin
                        bit_cnt_r <= 5'd0;
                        case (cmd_next_s)
                           OP_READ: begin
                              dummy_r <= 1'b0;
                              state_r <= ST_ADDR;
                           end
                           OP_FAST_READ: begin
                              dummy_r <= 1'b1;
                              state_r <= ST_ADDR;
                           end
                           default: begin
                              bad_cmd_r <= 1'b1;
                              state_r   <= ST_IGNORE;
                           end
                        endcase
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end

               ST_ADDR: begin
                  // Shifting 24 bits through addr_r keeps only the low
                  // BYTE_AW bits; the upper address bits fall off the top.
                  if (rise_s) begin
                     addr_r <= addr_next_s;
                     if (bit_cnt_r == 5'd23) begin
                        bit_cnt_r <= 5'd0;
                        if (dummy_r) begin
                           state_r <= ST_DUMMY;
                        end else begin
                           mem_word_addr_r <= addr_next_s[BYTE_AW-1:2];
                           mem_rstrb_r     <= 1'b1;
                           data_bit_r      <= 3'd0;
                           state_r         <= ST_DATA;
                        end
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end

               ST_DUMMY: begin
                  if (rise_s) begin
                     if (bit_cnt_r == 5'd7) begin
                        bit_cnt_r       <= 5'd0;
                        mem_word_addr_r <= addr_r[BYTE_AW-1:2];
                        mem_rstrb_r     <= 1'b1;
                        data_bit_r      <= 3'd0;
                        state_r         <= ST_DATA;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                     end
                  end
               end

               ST_DATA: begin
                  if (fall_s) begin
                     data_bit_r <= data_bit_r + 3'd1;
                     if (data_bit_r == 3'd0) begin
                        miso_r    <= lane_byte_s[7];
                        miso_sh_r <= {lane_byte_s[6:0], 1'b0};
                        addr_r    <= addr_inc_s;
                        // Leaving lane 3: the buffered word is exhausted, so
                        // prefetch the next one well before its first byte.
                        if (addr_r[1:0] == 2'd3) begin
                           mem_word_addr_r <= addr_inc_s[BYTE_AW-1:2];
                           mem_rstrb_r     <= 1'b1;
                        end else begin
                           mem_rstrb_r <= 1'b0;
                        end
                     end else begin
                        miso_r    <= miso_sh_r[7];
                        miso_sh_r <= {miso_sh_r[6:0], 1'b0};
                     end
                  end
               end

               ST_IGNORE, ST_WAIT_CS: begin
                  miso_r <= 1'b0;
               end

               default: begin
                  miso_r  <= 1'b0;
                  state_r <= ST_WAIT_CS;
               end
            endcase
         end
      end
   end

   assign bus.spi_miso      = miso_r;
   assign bus.mem_word_addr = mem_word_addr_r;
   assign bus.mem_rstrb     = mem_rstrb_r;
   assign bus.busy          = busy_r;
   assign bus.bad_cmd       = bad_cmd_r;

endmodule
